// File: rtl/leve1_csr_exec.sv
// rtl/leve1_csr_exec.sv - Zicsr execute-stage sequencer in front of the CSR register file.
// Optional LEVE1_CSR_CNTEN_CHECK_EN adds MCOUNTEREN gating of cycle/time/instret reads.

`ifndef CSR_NONE
`define CSR_NONE  2'b00
`endif
`ifndef CSR_WRITE
`define CSR_WRITE 2'b01
`endif
`ifndef CSR_SET
`define CSR_SET   2'b10
`endif
`ifndef CSR_CLEAR
`define CSR_CLEAR 2'b11
`endif

module leve1_csr_exec #(
    parameter int XLEN = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [2:0]      REQ_FUNCT3,
    input  logic [11:0]     REQ_CSR,
    input  logic [4:0]      REQ_RS1_IDX,
    input  logic [XLEN-1:0] REQ_RS1_VAL,
    input  logic [4:0]      REQ_RD,
    input  logic [1:0]      REQ_MODE,
`ifdef LEVE1_CSR_CNTEN_CHECK_EN
    input  logic [2:0]      MCOUNTEREN,
`endif
    output logic [11:0]     CSR_RA,
    input  logic [XLEN-1:0] CSR_RD,
    output logic [1:0]      CSR_WCMD,
    output logic [11:0]     CSR_WA,
    output logic [XLEN-1:0] CSR_WD,
    output logic            RSP_VALID,
    input  logic            RSP_READY,
    output logic            WB_EN,
    output logic [4:0]      WB_RD,
    output logic [XLEN-1:0] WB_DATA,
    output logic            EXC_VALID,
    output logic [XLEN-1:0] EXC_CAUSE,
    output logic [XLEN-1:0] EXC_TVAL,
    output logic            RETIRE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [11:0]       addr_q, addr_d;
    logic [XLEN-1:0]   operand_q, operand_d;
    logic [4:0]        rd_q, rd_d;
    logic [1:0]        cmd_q, cmd_d;
    logic              illegal_q, illegal_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic              req_do_write;
    logic [1:0]        req_cmd;
    logic [XLEN-1:0]   req_operand;
    logic              bad_funct3;
    logic              priv_fail;
    logic              ro_fail;
    logic              cnt_fail;
    logic              req_illegal;

    // Decode of the offered op; only consumed on the accepting cycle.
    always_comb begin
        req_operand  = REQ_FUNCT3[2] ? {{(XLEN-5){1'b0}}, REQ_RS1_IDX} : REQ_RS1_VAL;
        req_do_write = (REQ_FUNCT3[1:0] == 2'b01) || (REQ_RS1_IDX != 5'd0);
        unique case (REQ_FUNCT3[1:0])
            2'b01:   req_cmd = `CSR_WRITE;
            2'b10:   req_cmd = `CSR_SET;
            2'b11:   req_cmd = `CSR_CLEAR;
            default: req_cmd = `CSR_NONE;
        endcase
        bad_funct3 = (REQ_FUNCT3[1:0] == 2'b00);
        priv_fail  = (REQ_CSR[9:8] > REQ_MODE);
        ro_fail    = (REQ_CSR[11:10] == 2'b11) && req_do_write;
`ifdef LEVE1_CSR_CNTEN_CHECK_EN
        cnt_fail   = (REQ_CSR[11:2] == 10'h300) && (REQ_CSR[1:0] != 2'b11) &&
                     (REQ_MODE != 2'b11) && !MCOUNTEREN[REQ_CSR[1:0]];
`else
        cnt_fail   = 1'b0;
`endif
        req_illegal = bad_funct3 || priv_fail || ro_fail || cnt_fail;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        operand_d = operand_q;
        rd_d      = rd_q;
        cmd_d     = cmd_q;
        illegal_d = illegal_q;
        wb_data_d = wb_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    addr_d    = REQ_CSR;
                    operand_d = req_operand;
                    rd_d      = REQ_RD;
                    cmd_d     = req_do_write ? req_cmd : `CSR_NONE;
                    illegal_d = req_illegal;
                    state_d   = req_illegal ? S_RESP : S_READ;
                end
            end
            S_READ: begin
                wb_data_d = CSR_RD;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (RSP_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            addr_q    <= 12'd0;
            operand_q <= '0;
            rd_q      <= 5'd0;
            cmd_q     <= `CSR_NONE;
            illegal_q <= 1'b0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            operand_q <= operand_d;
            rd_q      <= rd_d;
            cmd_q     <= cmd_d;
            illegal_q <= illegal_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Every output is a function of state, so reset or an abort leaves them all quiet.
    always_comb begin
        REQ_READY = (state_q == S_IDLE);
        CSR_RA    = 12'd0;
        CSR_WCMD  = `CSR_NONE;
        CSR_WA    = 12'd0;
        CSR_WD    = '0;
        RSP_VALID = 1'b0;
        WB_EN     = 1'b0;
        WB_RD     = 5'd0;
        WB_DATA   = '0;
        EXC_VALID = 1'b0;
        EXC_CAUSE = '0;
        EXC_TVAL  = '0;
        RETIRE    = 1'b0;
        unique case (state_q)
            S_READ: begin
                CSR_RA = addr_q;
            end
            S_WRITE: begin
                CSR_WCMD = cmd_q;
                CSR_WA   = addr_q;
                CSR_WD   = operand_q;
            end
            S_RESP: begin
                RSP_VALID = 1'b1;
                WB_RD     = rd_q;
                if (illegal_q) begin
                    EXC_VALID = 1'b1;
                    EXC_CAUSE = XLEN'(2);
                    EXC_TVAL  = {{(XLEN-12){1'b0}}, addr_q};
                end else begin
                    WB_EN   = (rd_q != 5'd0);
                    WB_DATA = wb_data_q;
                    RETIRE  = RSP_READY;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_leve1_csr_exec.sv
// tb/tb_leve1_csr_exec.sv - scoreboard bench for leve1_csr_exec with a behavioural CSR file.

module tb_leve1_csr_exec;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_SET   = 2'b10;
    localparam logic [1:0] C_CLEAR = 2'b11;

    typedef struct packed {
        logic        wb_en;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        exc;
        logic [63:0] tval;
    } rsp_t;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [11:0] wa;
        logic [63:0] wd;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr;
    logic [4:0]  req_rs1_idx;
    logic [63:0] req_rs1_val;
    logic [4:0]  req_rd;
    logic [1:0]  req_mode;
`ifdef LEVE1_CSR_CNTEN_CHECK_EN
    logic [2:0]  mcounteren;
`endif
    logic [11:0] csr_ra;
    logic [63:0] csr_rd;
    logic [1:0]  csr_wcmd;
    logic [11:0] csr_wa;
    logic [63:0] csr_wd;
    logic        rsp_valid, rsp_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        exc_valid;
    logic [63:0] exc_cause, exc_tval;
    logic        retire;

    logic [63:0] csr_mem [0:4095];
    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    int          total = 0;
    int          bad = 0;
    int          retire_seen = 0;
    int          retire_exp = 0;

    always #5 clk = ~clk;

    leve1_csr_exec #(.XLEN(64)) dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_FUNCT3(req_funct3), .REQ_CSR(req_csr),
        .REQ_RS1_IDX(req_rs1_idx), .REQ_RS1_VAL(req_rs1_val),
        .REQ_RD(req_rd), .REQ_MODE(req_mode),
`ifdef LEVE1_CSR_CNTEN_CHECK_EN
        .MCOUNTEREN(mcounteren),
`endif
        .CSR_RA(csr_ra), .CSR_RD(csr_rd),
        .CSR_WCMD(csr_wcmd), .CSR_WA(csr_wa), .CSR_WD(csr_wd),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
        .WB_EN(wb_en), .WB_RD(wb_rd), .WB_DATA(wb_data),
        .EXC_VALID(exc_valid), .EXC_CAUSE(exc_cause), .EXC_TVAL(exc_tval),
        .RETIRE(retire)
    );

    assign csr_rd = csr_mem[csr_ra];

    always @(posedge clk) begin
        if (!rst) begin
            case (csr_wcmd)
                C_WRITE: csr_mem[csr_wa] <= csr_wd;
                C_SET:   csr_mem[csr_wa] <= csr_mem[csr_wa] | csr_wd;
                C_CLEAR: csr_mem[csr_wa] <= csr_mem[csr_wa] & ~csr_wd;
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("wb_en", {63'd0, wb_en}, {63'd0, e.wb_en});
                chk("exc_valid", {63'd0, exc_valid}, {63'd0, e.exc});
                chk("exc_cause", exc_cause, e.exc ? 64'd2 : 64'd0);
                chk("exc_tval", exc_tval, e.tval);
                chk("retire", {63'd0, retire}, {63'd0, !e.exc});
                if (!e.exc) begin
                    chk("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
                    chk("wb_data", wb_data, e.data);
                end
            end
        end else if (retire) begin
            chk("retire_no_handshake", 64'd1, 64'd0);
        end
        if (retire) retire_seen++;
    end

    // Write-port monitor
    always @(negedge clk) begin
        if (!rst && csr_wcmd != C_NONE) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", {62'd0, csr_wcmd}, 64'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("csr_wcmd", {62'd0, csr_wcmd}, {62'd0, w.cmd});
                chk("csr_wa", {52'd0, csr_wa}, {52'd0, w.wa});
                chk("csr_wd", csr_wd, w.wd);
            end
        end
    end

    task automatic send(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] idx,
                        input logic [63:0] val, input logic [4:0] rd, input logic [1:0] mode);
        bit ok = 0;
        req_funct3 = f3; req_csr = csr; req_rs1_idx = idx;
        req_rs1_val = val; req_rd = rd; req_mode = mode;
        req_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) chk("req_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int exp_lat);
        int lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = n; break; end
        end
        chk("latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic expect_op(input logic [11:0] csr, input logic [4:0] rd, input bit exc,
                             input logic [63:0] data, input bit wr, input logic [1:0] cmd,
                             input logic [63:0] wd);
        rsp_q.push_back('{wb_en: (!exc && rd != 5'd0), rd: rd, data: data, exc: exc,
                          tval: exc ? {52'd0, csr} : 64'd0});
        if (wr) wr_q.push_back('{cmd: cmd, wa: csr, wd: wd});
    endtask

    task automatic op(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] idx,
                      input logic [63:0] val, input logic [4:0] rd, input logic [1:0] mode,
                      input bit exc, input logic [63:0] data, input bit wr,
                      input logic [1:0] cmd, input logic [63:0] wd);
        expect_op(csr, rd, exc, data, wr, cmd, wd);
        if (!exc) retire_exp++;
        send(f3, csr, idx, val, rd, mode);
        wait_rsp(exc ? 1 : 3);
        @(posedge clk); #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        chk({tag, "_outs"}, {52'd0, csr_ra} | {52'd0, csr_wa} | csr_wd | wb_data | exc_cause |
            exc_tval | {59'd0, wb_rd}, 64'd0);
        chk({tag, "_flags"}, {58'd0, csr_wcmd, rsp_valid, wb_en, exc_valid, retire}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) csr_mem[i] = 64'd0;
        csr_mem[12'h305] = 64'h1000;
        csr_mem[12'hC00] = 64'd12345;
        csr_mem[12'hC01] = 64'h2222;
        csr_mem[12'h141] = 64'h77;
        csr_mem[12'hF14] = 64'h2A;
`ifdef LEVE1_CSR_CNTEN_CHECK_EN
        mcounteren = 3'b101;
`endif
        rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'd0; req_csr = 12'd0;
        req_rs1_idx = 5'd0; req_rs1_val = 64'd0; req_rd = 5'd0; req_mode = 2'd0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        //  f3    csr     idx    val            rd     mode  exc data           wr cmd      wd
        op(3'b001, 12'h305, 5'd1, 64'h8000_0000, 5'd5, 2'b11, 0, 64'h1000,      1, C_WRITE, 64'h8000_0000);
        op(3'b010, 12'h305, 5'd0, 64'hFFFF,      5'd6, 2'b11, 0, 64'h8000_0000, 0, C_NONE,  64'd0);
        op(3'b010, 12'hC00, 5'd0, 64'd0,         5'd7, 2'b00, 0, 64'd12345,     0, C_NONE,  64'd0);
        op(3'b001, 12'hF14, 5'd2, 64'd5,         5'd3, 2'b11, 1, 64'd0,         0, C_NONE,  64'd0);
        op(3'b110, 12'h300, 5'd8, 64'd0,         5'd4, 2'b01, 1, 64'd0,         0, C_NONE,  64'd0);
        op(3'b000, 12'h340, 5'd1, 64'd1,         5'd2, 2'b11, 1, 64'd0,         0, C_NONE,  64'd0);
        op(3'b100, 12'h340, 5'd1, 64'd1,         5'd2, 2'b11, 1, 64'd0,         0, C_NONE,  64'd0);
        op(3'b110, 12'h340, 5'd5, 64'd0,         5'd9, 2'b11, 0, 64'd0,         1, C_SET,   64'd5);
        op(3'b011, 12'h340, 5'd1, 64'd4,        5'd10, 2'b11, 0, 64'd5,         1, C_CLEAR, 64'd4);
        op(3'b111, 12'h305, 5'd31, 64'd0,        5'd0, 2'b11, 0, 64'h8000_0000, 1, C_CLEAR, 64'h1F);
        op(3'b101, 12'h141, 5'd0, 64'hDEAD,     5'd11, 2'b01, 0, 64'h77,        1, C_WRITE, 64'd0);
        op(3'b010, 12'h141, 5'd0, 64'd0,        5'd12, 2'b00, 1, 64'd0,         0, C_NONE,  64'd0);
        op(3'b010, 12'hF14, 5'd0, 64'd0,        5'd13, 2'b11, 0, 64'h2A,        0, C_NONE,  64'd0);
`ifdef LEVE1_CSR_CNTEN_CHECK_EN
        op(3'b010, 12'hC01, 5'd0, 64'd0,        5'd14, 2'b01, 1, 64'd0,         0, C_NONE,  64'd0);
`else
        op(3'b010, 12'hC01, 5'd0, 64'd0,        5'd14, 2'b01, 0, 64'h2222,      0, C_NONE,  64'd0);
`endif
        op(3'b010, 12'hC00, 5'd0, 64'd0,        5'd15, 2'b01, 0, 64'd12345,     0, C_NONE,  64'd0);

        // Backpressure: response must hold, then reset drops it without RETIRE.
        rsp_ready = 1'b0;
        expect_op(12'h305, 5'd5, 0, 64'h8000_0000, 1, C_WRITE, 64'hAA);
        send(3'b001, 12'h305, 5'd1, 64'hAA, 5'd5, 2'b11);
        wait_rsp(3);
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_wb", {wb_en, exc_valid, retire, wb_rd}, {1'b1, 1'b0, 1'b0, 5'd5});
            chk("bp_wb_data", wb_data, 64'h8000_0000);
            chk("bp_wcmd", {62'd0, csr_wcmd}, 64'd0);
            @(negedge clk);
        end
        #1 rst = 1'b1;
        rsp_ready = 1'b1;
        void'(rsp_q.pop_front());
        @(negedge clk);
        chk_idle("bp_reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset during READ: the pending write must never reach the CSR file.
        send(3'b001, 12'h340, 5'd3, 64'h99, 5'd8, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        op(3'b010, 12'h340, 5'd0, 64'd0, 5'd8, 2'b11, 0, 64'd1,  0, C_NONE, 64'd0);
        op(3'b010, 12'h305, 5'd0, 64'd0, 5'd5, 2'b11, 0, 64'hAA, 0, C_NONE, 64'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        chk("retire_count", 64'(retire_seen), 64'(retire_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
